// File: rtl/sp_ram_arb_pkg.sv
// rtl/sp_ram_arb_pkg.sv - shared types and default widths for the sp_ram arbiter
//
// Purpose: sequencer state encoding, default RAM geometry and the request
//          record used by the sp_ram arbiter files.
// Ports:   none (package).

package sp_ram_arb_pkg;

   localparam int DEF_ADDR_W = 6;
   localparam int DEF_DATA_W = 8;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
   } req_t;

endpackage

// File: rtl/sp_ram_arb_if.sv
// rtl/sp_ram_arb_if.sv - requester-side bus bundle for the sp_ram arbiter
//
// Purpose: groups the per-requester request handshake and the read response.
// Signals: req_valid/req_ready - per-requester request handshake
//          req_we/req_addr/req_wdata - access type, address, write data
//          rsp_valid - per-requester read-data strobe
//          rsp_rdata - shared read data bus
// Modports: master (client side), slave (arbiter side).

interface sp_ram_arb_if
   import sp_ram_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W
);

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ-1:0]             req_we;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]             rsp_valid;
   logic [DATA_W-1:0]              rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/sp_ram_rr_arb.sv
// rtl/sp_ram_rr_arb.sv - round-robin one-hot grant generator
//
// Purpose: picks the first pending request at or after the rotating pointer
//          and advances the pointer past the winner.
// Ports:   clk, rst_n        - clock, asynchronous active-low reset
//          en                - grants allowed this cycle
//          req[NUM_REQ]      - pending requests
//          grant[NUM_REQ]    - one-hot grant (all zero when nothing wins)
//          gnt_any           - a grant was issued
//          gnt_idx           - index of the winner (valid with gnt_any)

module sp_ram_rr_arb
   import sp_ram_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               gnt_any,
   output logic [IDX_W-1:0]   gnt_idx
);

   logic [IDX_W-1:0] rr_ptr;

   always_comb begin
      int               c;
      logic [IDX_W-1:0] ci;
      c       = 0;
      ci      = '0;
      grant   = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      // Walk the requesters starting at rr_ptr, wrapping modulo NUM_REQ
      // (NUM_REQ need not be a power of two, so the wrap is explicit).
      for (int k = 0; k < NUM_REQ; k++) begin
         c = int'(rr_ptr) + k;
         if (c >= NUM_REQ) begin
            c = c - NUM_REQ;
         end
         ci = IDX_W'(c);
         if (en && !gnt_any && req[ci]) begin
            gnt_any = 1'b1;
            gnt_idx = ci;
         end
      end
      if (gnt_any) begin
         grant[gnt_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (gnt_any) begin
         rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/sp_ram_arb.sv
// rtl/sp_ram_arb.sv - clear-then-arbitrate sequencer in front of one sp_ram
//
// Purpose: after reset sweeps INIT_VAL into every RAM word, then shares the
//          single-port RAM between NUM_REQ requesters, one access per cycle,
//          round-robin. Reads return on the shared bus with a per-requester
//          strobe one cycle after the grant.
// Ports:   clk, rst_n  - clock, asynchronous active-low reset
//          bus         - requester bundle (slave side)
//          init_done   - clear sweep finished
//          ram_we/ram_addr/ram_data - straight to sp_ram we/addr/data
//          ram_q       - from sp_ram q

module sp_ram_arb
   import sp_ram_arb_pkg::*;
#(
   parameter int                NUM_REQ  = 2,
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   sp_ram_arb_if.slave       bus,
   output logic              init_done,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   input  logic [DATA_W-1:0] ram_q
);

   localparam int IDX_W = $clog2(NUM_REQ);

   state_t             state;
   state_t             state_nxt;
   logic [ADDR_W-1:0]  init_addr;
   logic [NUM_REQ-1:0] grant;
   logic               gnt_any;
   logic [IDX_W-1:0]   gnt_idx;

   // Grants are held off for the whole sweep, so req_valid is ignored in INIT.
   sp_ram_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (state == RUN),
      .req     (bus.req_valid),
      .grant   (grant),
      .gnt_any (gnt_any),
      .gnt_idx (gnt_idx)
   );

   assign bus.req_ready = grant;
   assign bus.rsp_rdata = ram_q;

   always_comb begin
      state_nxt = state;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_data  = '0;
      case (state)
         INIT: begin
            ram_we   = 1'b1;
            ram_addr = init_addr;
            ram_data = INIT_VAL;
            if (&init_addr) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (gnt_any) begin
               ram_we   = bus.req_we[gnt_idx];
               ram_addr = bus.req_addr[gnt_idx];
               ram_data = bus.req_wdata[gnt_idx];
            end
         end
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= INIT;
         init_addr     <= '0;
         init_done     <= 1'b0;
         bus.rsp_valid <= '0;
      end else begin
         state <= state_nxt;
         // Wraps back to 0 on the last sweep write and then stays there.
         if (state == INIT) begin
            init_addr <= init_addr + ADDR_W'(1);
         end
         init_done     <= (state_nxt == RUN);
         // RAM read latency is one cycle, so the strobe lines up with ram_q.
         bus.rsp_valid <= grant & ~bus.req_we;
      end
   end

endmodule

// File: tb/tb_sp_ram_arb.sv
// tb/tb_sp_ram_arb.sv - directed self-checking bench for sp_ram_arb
//
// Purpose: drives the arbiter through reset/clear, solo traffic, contention,
//          write-then-read forwarding through the RAM and reset mid-operation,
//          with a behavioural 64x8 synchronous-read RAM attached.
// Ports:   none (top-level bench).

module tb_sp_ram_arb;

   logic       clk;
   logic       rst_n;
   logic       init_done;
   logic       ram_we;
   logic [5:0] ram_addr;
   logic [7:0] ram_data;
   logic [7:0] ram_q;
   logic [7:0] mem [64];
   logic [7:0] vals [64];

   int n_tests;
   int n_fail;

   sp_ram_arb_if #(.NUM_REQ(2), .ADDR_W(6), .DATA_W(8)) bus ();

   sp_ram_arb #(
      .NUM_REQ  (2),
      .ADDR_W   (6),
      .DATA_W   (8),
      .INIT_VAL (8'h00)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .init_done (init_done),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_q     (ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] we,
                        input logic [5:0] a0, input logic [5:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1);
      @(posedge clk);
      #1;
      bus.req_valid = v;
      bus.req_we    = we;
      bus.req_addr  = {a1, a0};
      bus.req_wdata = {d1, d0};
   endtask

   task automatic expect_cycle(input string tag, input logic [1:0] rdy,
                               input logic [1:0] rsp, input logic [7:0] data);
      @(negedge clk);
      chk({tag, ".ready"}, bus.req_ready, rdy);
      chk({tag, ".rsp_valid"}, bus.rsp_valid, rsp);
      if (rsp != 2'b00) chk({tag, ".rdata"}, bus.rsp_rdata, data);
      if (rdy == 2'b00) begin
         chk({tag, ".idle_we"}, ram_we, 1'b0);
         chk({tag, ".idle_addr"}, ram_addr, 6'd0);
      end
   endtask

   // Caller releases reset at posedge+1 with requester 0 reading address 0.
   task automatic init_sweep(input string tag);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         chk($sformatf("%s.we%0d", tag, i), ram_we, 1'b1);
         chk($sformatf("%s.addr%0d", tag, i), ram_addr, i);
         chk($sformatf("%s.data%0d", tag, i), ram_data, 8'h00);
         chk($sformatf("%s.done%0d", tag, i), init_done, 1'b0);
         chk($sformatf("%s.ready%0d", tag, i), bus.req_ready, 2'b00);
         chk($sformatf("%s.rsp%0d", tag, i), bus.rsp_valid, 2'b00);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk({tag, ".done_rise"}, init_done, 1'b1);
      chk({tag, ".first_grant"}, bus.req_ready, 2'b01);
      chk({tag, ".first_rsp"}, bus.rsp_valid, 2'b00);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.req_valid = 2'b00;
      bus.req_we    = 2'b00;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      // Reset, clear sweep, requester 0 pending throughout INIT.
      repeat (3) @(posedge clk);
      #1;
      bus.req_valid = 2'b01;
      rst_n         = 1'b1;
      init_sweep("init1");
      for (int i = 1; i < 64; i++) begin
         drive(2'b01, 2'b00, 6'(i), 6'd0, 8'h00, 8'h00);
         expect_cycle($sformatf("clr_rd%0d", i), 2'b01, 2'b01, 8'h00);
      end
      drive(2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00);
      expect_cycle("clr_rd_tail", 2'b00, 2'b01, 8'h00);

      // Requester 0 alone: write 64 values then read back without bubbles.
      for (int i = 0; i < 64; i++) vals[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 64; i++) begin
         drive(2'b01, 2'b01, 6'(i), 6'd0, vals[i], 8'h00);
         expect_cycle($sformatf("wr%0d", i), 2'b01, 2'b00, 8'h00);
      end
      for (int i = 0; i < 64; i++) begin
         drive(2'b01, 2'b00, 6'(i), 6'd0, 8'h00, 8'h00);
         expect_cycle($sformatf("rd%0d", i), 2'b01, (i == 0) ? 2'b00 : 2'b01,
                      (i == 0) ? 8'h00 : vals[i-1]);
      end
      drive(2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00);
      expect_cycle("rd_tail", 2'b00, 2'b01, vals[63]);

      // Write by requester 1, read of same address by requester 0 next cycle.
      drive(2'b10, 2'b10, 6'd0, 6'h2A, 8'h00, 8'hA5);
      expect_cycle("fwd_wr", 2'b10, 2'b00, 8'h00);
      drive(2'b01, 2'b00, 6'h2A, 6'd0, 8'h00, 8'h00);
      expect_cycle("fwd_rd", 2'b01, 2'b00, 8'h00);
      drive(2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00);
      expect_cycle("fwd_rsp", 2'b00, 2'b01, 8'hA5);
      // Extra requester-1 write leaves the pointer back at requester 0.
      drive(2'b10, 2'b10, 6'd0, 6'h05, 8'h00, 8'h3C);
      expect_cycle("wr_r1", 2'b10, 2'b00, 8'h00);

      // Both requesters reading continuously: strict alternation from 0.
      for (int i = 0; i < 8; i++) begin
         drive(2'b11, 2'b00, 6'h2A, 6'h05, 8'h00, 8'h00);
         expect_cycle($sformatf("rr%0d", i), (i % 2 == 0) ? 2'b01 : 2'b10,
                      (i == 0) ? 2'b00 : ((i % 2 == 0) ? 2'b10 : 2'b01),
                      (i % 2 == 0) ? 8'h3C : 8'hA5);
      end
      drive(2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00);
      expect_cycle("rr_tail", 2'b00, 2'b10, 8'h3C);

      // Reset in the cycle after a read grant.
      drive(2'b01, 2'b00, 6'h05, 6'd0, 8'h00, 8'h00);
      expect_cycle("pre_rst_rd", 2'b01, 2'b00, 8'h00);
      @(posedge clk);
      #1;
      rst_n         = 1'b0;
      bus.req_valid = 2'b01;
      bus.req_addr  = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rst_rsp%0d", i), bus.rsp_valid, 2'b00);
         chk($sformatf("rst_ready%0d", i), bus.req_ready, 2'b00);
         chk($sformatf("rst_done%0d", i), init_done, 1'b0);
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
      init_sweep("init2");
      drive(2'b01, 2'b00, 6'h05, 6'd0, 8'h00, 8'h00);
      expect_cycle("post_rst_rd0", 2'b01, 2'b01, 8'h00);
      drive(2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00);
      expect_cycle("post_rst_rd5", 2'b00, 2'b01, 8'h00);
      drive(2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00);
      expect_cycle("post_rst_idle", 2'b00, 2'b00, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sp_ram_arb.md
Name: sp_ram_arb

Overview:
- Round-robin arbiter and sequencer sharing one sp_ram instance (64x8, single port, synchronous read, 1-cycle read latency) between NUM_REQ requesters.
- After reset it runs a clear sweep, writing INIT_VAL to every location, then grants at most one access per cycle.
- Read data returns with a per-requester valid strobe.
- Sits between client logic and the sp_ram macro; ram_* ports connect directly to sp_ram we/addr/data/q.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- INIT_VAL, 8'h00, value written to every location during the clear sweep.

Ports:
- clk  in  1  single clock; all state on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request valid per requester.
- req_ready  out  NUM_REQ  grant; the request is accepted when req_valid[i] && req_ready[i].
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ x ADDR_W  address per requester.
- req_wdata  in  NUM_REQ x DATA_W  write data per requester.
- rsp_valid  out  NUM_REQ  read data valid for requester i.
- rsp_rdata  out  DATA_W  shared read data bus, equal to ram_q.
- init_done  out  1  high once the clear sweep has finished.
- ram_we  out  1  to sp_ram we.
- ram_addr  out  ADDR_W  to sp_ram addr.
- ram_data  out  DATA_W  to sp_ram data.
- ram_q  in  DATA_W  from sp_ram q.

Behaviour:
- FSM states: INIT, RUN. There are no other states.
- Reset (asynchronous assert; release synchronous to clk) sets:
  - state = INIT, init_addr = 0, rr_ptr = 0;
  - rsp_valid = 0, init_done = 0.
  - During INIT, req_ready = 0.
- INIT:
  - Combinational outputs: ram_we = 1, ram_addr = init_addr, ram_data = INIT_VAL.
  - init_addr increments each cycle.
  - When init_addr == DEPTH-1, the next state is RUN.
  - The sweep takes exactly DEPTH cycles. init_done is a registered output that goes high on the first RUN cycle.
  - req_valid is ignored during INIT.
- RUN arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ. The first set bit wins.
  - req_ready is one-hot for the winner, or all zero if no request is pending.
  - After a grant, rr_ptr <= (winner+1) mod NUM_REQ. With no grant, rr_ptr holds.
  - A lone requester is granted every cycle.
  - req_ready may depend on req_valid; req_valid must not depend on req_ready. A requester holds valid, we, addr and wdata stable until it is granted.
- RAM drive in RUN (combinational):
  - With a grant: ram_we = req_we[w], ram_addr = req_addr[w], ram_data = req_wdata[w].
  - With no grant: ram_we = 0, ram_addr = 0, ram_data = 0.
- Read response:
  - rsp_valid[w] is registered high for exactly one cycle, in the cycle after a read grant.
  - In that cycle rsp_rdata = ram_q.
- Writes produce no response.
- Back-to-back accesses:
  - A write granted in cycle k followed by a read of the same address granted in cycle k+1 returns the new data in cycle k+2.
  - Consecutive read grants give one rsp_valid per cycle, with no bubbles.
- The fairness bound follows from the rotation: with all requesters continuously valid, each is granted once every NUM_REQ cycles.
- Reset mid-operation:
  - Clears all state, drops pending responses and restarts the INIT sweep.
  - RAM contents written before the reset are overwritten by the sweep.

Decomposition:
- Package sp_ram_arb_pkg holds:
  - the state enum typedef (INIT, RUN);
  - default ADDR_W/DATA_W localparams;
  - a request struct typedef {we, addr, wdata}.
- Sub-module sp_ram_rr_arb holds the round-robin pointer and the one-hot grant logic, parameterised by NUM_REQ.
- The top level holds the FSM, the init counter, the RAM mux and the response registers.

Test Plan:
1. Reset, then idle. Required: init_done rises exactly 64 cycles after rst_n deasserts; ram_we = 1 with ram_addr 0..63 during INIT; afterwards, reading addresses 0..63 returns 8'h00 at all 64.
2. Requester 0 alone writes 64 $random values to addresses 0..63, then reads them back. Required: one grant per cycle; each rsp_valid[0] carries the matching value; rsp_valid[1] stays 0.
3. Both requesters hold valid continuously for 8 cycles. Required: grants alternate 0,1,0,1,..., starting at 0, with 4 grants each.
4. Requester 1 writes 8'hA5 to address 6'h2A in cycle k; requester 0 reads 6'h2A in cycle k+1. Required: rsp_valid[0] = 1 and rsp_rdata = 8'hA5 in cycle k+2.
5. Requester 0 asserts valid during INIT. Required: req_ready stays 0 until the first RUN cycle, in which it is granted.
6. Assert rst_n low in the cycle after a read grant. Required: rsp_valid clears immediately and never pulses; INIT restarts from address 0 and completes in 64 cycles; a subsequent read of the previously written address returns 8'h00.
